// File: rtl/interp_pkg.sv
// Shared constants, coefficient table and helper functions for interp_fir_pipe.
//   Widths: IN_W input pixel, OUT_W output pixel, COEF_W signed coefficient,
//   PROD_W per-tap product, ACC_W tap-sum accumulator.
//   COEF_TABLE[phase][tap]: tap 0 is the oldest sample; each row sums to 2^SHIFT.
package interp_pkg;

  localparam int unsigned IN_W   = 8;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned COEF_W = 8;
  localparam int unsigned N_TAPS = 4;
  localparam int unsigned PHASES = 16;
  localparam int unsigned SHIFT  = 6;

  localparam int unsigned PH_W   = $clog2(PHASES);
  localparam int unsigned FILL_W = $clog2(N_TAPS + 1);
  localparam int unsigned PROD_W = IN_W + COEF_W + 1;
  localparam int unsigned ACC_W  = PROD_W + $clog2(N_TAPS);
  localparam int unsigned ROUND  = 1 << (SHIFT - 1);
  localparam int          PIX_MAX = (1 << OUT_W) - 1;

  // 1/16-sample chroma-style 4-tap interpolation rows, mirror-symmetric about phase 8.
  localparam int COEF_TABLE [PHASES][N_TAPS] = '{
    '{ 0, 64,  0,  0},
    '{-2, 62,  4,  0},
    '{-2, 58, 10, -2},
    '{-4, 56, 14, -2},
    '{-4, 54, 16, -2},
    '{-6, 52, 20, -2},
    '{-6, 46, 28, -4},
    '{-4, 42, 30, -4},
    '{-4, 36, 36, -4},
    '{-4, 30, 42, -4},
    '{-4, 28, 46, -6},
    '{-2, 20, 52, -6},
    '{-2, 16, 54, -4},
    '{-2, 14, 56, -4},
    '{-2, 10, 58, -2},
    '{ 0,  4, 62, -2}
  };

  // Per-stage pipeline tag.
  typedef struct packed {
    logic valid;
    logic eol;
  } pipe_tag_t;

  // Out-of-range phase codes fall back to the integer-position row.
  function automatic logic [PH_W-1:0] phase_sel(input logic [PH_W-1:0] ph);
    return (int'(ph) < int'(PHASES)) ? ph : '0;
  endfunction

  // Multiply by a constant coefficient as a sum of shifted copies of x.
  function automatic logic signed [PROD_W-1:0] shift_add_mult(input logic [IN_W-1:0] x,
                                                             input int coef);
    logic signed [PROD_W-1:0] acc;
    logic signed [PROD_W-1:0] xs;
    int mag;
    acc = '0;
    xs  = PROD_W'(x);
    mag = (coef < 0) ? -coef : coef;
    for (int b = 0; b < int'(COEF_W); b++) begin
      if (((mag >> b) & 1) != 0) acc = acc + (xs <<< b);
    end
    return (coef < 0) ? -acc : acc;
  endfunction

  // Saturate a signed filter result into the unsigned output pixel range.
  function automatic logic [OUT_W-1:0] clip_pix(input logic signed [ACC_W-1:0] r);
    if (int'(r) < 0) return '0;
    if (int'(r) > PIX_MAX) return '1;
    return r[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/interp_coef_mult.sv
// Phase-selected constant multiplier for one filter tap (combinational).
//   pix    : window sample at this tap
//   phase  : coefficient row (already range-checked by the parent)
//   prod_c : signed product pix * COEF_TABLE[phase][TAP]
module interp_coef_mult
  import interp_pkg::*;
#(
  parameter int unsigned TAP = 0
) (
  input  logic [IN_W-1:0]          pix,
  input  logic [PH_W-1:0]          phase,
  output logic signed [PROD_W-1:0] prod_c
);

  logic signed [PROD_W-1:0] row_prod [PHASES];

  // One fixed shift-add network per phase; the phase only steers the result mux.
  for (genvar p = 0; p < int'(PHASES); p++) begin : g_phase
    assign row_prod[p] = shift_add_mult(pix, COEF_TABLE[p][TAP]);
  end

  assign prod_c = row_prod[phase];

endmodule

// File: rtl/interp_fir_pipe.sv
// Streaming N_TAPS fractional-sample interpolation filter with valid/ready flow.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input handshake (in_ready is the global pipeline enable)
//   in_pix, in_phase    : sample and coefficient row for the window it completes
//   in_sol, in_eol      : row start / row end markers
//   out_valid/out_ready : output handshake
//   out_pix, out_eol    : rounded, clipped result and the completing beat's eol
// Stages: 0 window shift, 1 per-tap products, 2 sum/round/shift, 3 clip.
module interp_fir_pipe
  import interp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_pix,
  input  logic [PH_W-1:0]  in_phase,
  input  logic             in_sol,
  input  logic             in_eol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_pix,
  output logic             out_eol
);

  logic                     en;
  logic                     accept;
  logic [IN_W-1:0]          taps_q [N_TAPS];
  logic [FILL_W-1:0]        fill_q;
  logic [FILL_W-1:0]        fill_next;
  logic                     win_done;
  logic [PH_W-1:0]          ph0_q;
  pipe_tag_t                tag0_q;
  pipe_tag_t                tag1_q;
  pipe_tag_t                tag2_q;
  logic signed [PROD_W-1:0] prod_c [N_TAPS];
  logic signed [PROD_W-1:0] prod_q [N_TAPS];
  logic signed [ACC_W-1:0]  acc_c;
  logic signed [ACC_W-1:0]  r_q;

  // Whole pipe advances together; it only stalls when a result is waiting.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;

  // Fill count after this beat: a row start counts only itself, otherwise saturate.
  always_comb begin
    fill_next = fill_q;
    if (in_sol) begin
      fill_next = FILL_W'(1);
    end else if (fill_q < FILL_W'(N_TAPS)) begin
      fill_next = fill_q + FILL_W'(1);
    end
  end

  assign win_done = (fill_next == FILL_W'(N_TAPS));

  // Stage 0: sliding window, newest sample enters at the top tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(N_TAPS); k++) taps_q[k] <= '0;
      fill_q <= '0;
      ph0_q  <= '0;
      tag0_q <= '0;
    end else if (en) begin
      tag0_q.valid <= accept & win_done;
      if (accept) begin
        for (int k = 0; k < int'(N_TAPS) - 1; k++) taps_q[k] <= taps_q[k+1];
        taps_q[N_TAPS-1] <= in_pix;
        fill_q           <= fill_next;
        ph0_q            <= phase_sel(in_phase);
        tag0_q.eol       <= in_eol;
      end
    end
  end

  for (genvar k = 0; k < int'(N_TAPS); k++) begin : g_tap
    interp_coef_mult #(
      .TAP(k)
    ) u_mult (
      .pix   (taps_q[k]),
      .phase (ph0_q),
      .prod_c(prod_c[k])
    );
  end

  // Stage 1: register tap products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(N_TAPS); k++) prod_q[k] <= '0;
      tag1_q <= '0;
    end else if (en) begin
      for (int k = 0; k < int'(N_TAPS); k++) prod_q[k] <= prod_c[k];
      tag1_q <= tag0_q;
    end
  end

  // Tap sum with half-LSB rounding offset ahead of the normalising shift.
  always_comb begin
    acc_c = ACC_W'(ROUND);
    for (int k = 0; k < int'(N_TAPS); k++) acc_c = acc_c + ACC_W'(prod_q[k]);
  end

  // Stage 2: arithmetic shift floors negative sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      tag2_q <= '0;
    end else if (en) begin
      r_q    <= acc_c >>> SHIFT;
      tag2_q <= tag1_q;
    end
  end

  // Stage 3: clip into the output pixel range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_eol   <= 1'b0;
    end else if (en) begin
      out_valid <= tag2_q.valid;
      out_pix   <= clip_pix(r_q);
      out_eol   <= tag2_q.eol;
    end
  end

endmodule

// File: tb/tb_interp_fir_pipe.sv
// Self-checking bench for interp_fir_pipe: behavioural row/window model with
// an expected-output queue, directed rows plus randomized traffic and back-pressure.
module tb_interp_fir_pipe;

  localparam int NT = 4;
  localparam int TB_COEF [16][NT] = '{
    '{ 0, 64,  0,  0}, '{-2, 62,  4,  0}, '{-2, 58, 10, -2}, '{-4, 56, 14, -2},
    '{-4, 54, 16, -2}, '{-6, 52, 20, -2}, '{-6, 46, 28, -4}, '{-4, 42, 30, -4},
    '{-4, 36, 36, -4}, '{-4, 30, 42, -4}, '{-4, 28, 46, -6}, '{-2, 20, 52, -6},
    '{-2, 16, 54, -4}, '{-2, 14, 56, -4}, '{-2, 10, 58, -2}, '{ 0,  4, 62, -2}
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pix;
  logic [3:0] in_phase;
  logic       in_sol;
  logic       in_eol;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pix;
  logic       out_eol;

  int n_checks = 0;
  int n_fail   = 0;

  int row_q[$];
  int exp_pix_q[$];
  bit exp_eol_q[$];
  bit held_v = 1'b0;
  logic [7:0] held_pix;
  logic       held_eol;
  bit rnd_done = 1'b0;

  interp_fir_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pix   (in_pix),
    .in_phase (in_phase),
    .in_sol   (in_sol),
    .in_eol   (in_eol),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pix  (out_pix),
    .out_eol  (out_eol)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkn(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference filter: plain integer dot product, rounding, floor shift, clamp.
  function automatic int model_filt(input int w[NT], input int phase);
    int s;
    int ph;
    ph = (phase >= 16) ? 0 : phase;
    s = 32;
    for (int k = 0; k < NT; k++) s += w[k] * TB_COEF[ph][k];
    s = s >>> 6;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  // Model + compare, sampled mid-cycle while inputs and outputs are stable.
  always @(negedge clk) begin
    int w[NT];
    int e;
    bit ee;
    if (!rst_n) begin
      row_q.delete();
      exp_pix_q.delete();
      exp_eol_q.delete();
      held_v = 1'b0;
    end else begin
      check1("in_ready_rule", in_ready, !out_valid || out_ready);
      if (held_v) begin
        check1("hold_valid", out_valid, 1'b1);
        checkn("hold_pix", 32'(out_pix), 32'(held_pix));
        check1("hold_eol", out_eol, held_eol);
      end
      held_v   = out_valid && !out_ready;
      held_pix = out_pix;
      held_eol = out_eol;
      if (out_valid && out_ready) begin
        if (exp_pix_q.size() == 0) begin
          check1("spurious_out", out_valid, 1'b0);
        end else begin
          e  = exp_pix_q.pop_front();
          ee = exp_eol_q.pop_front();
          checkn("out_pix", 32'(out_pix), 32'(e));
          check1("out_eol", out_eol, ee);
        end
      end
      if (in_valid && in_ready) begin
        if (in_sol) row_q.delete();
        row_q.push_back(int'(in_pix));
        if (row_q.size() > NT) void'(row_q.pop_front());
        if (row_q.size() == NT) begin
          for (int k = 0; k < NT; k++) w[k] = row_q[k];
          exp_pix_q.push_back(model_filt(w, int'(in_phase)));
          exp_eol_q.push_back(in_eol);
        end
      end
    end
  end

  task automatic send(input int pix, input int ph, input bit sol, input bit eol);
    int waited = 0;
    in_valid = 1'b1;
    in_pix   = 8'(pix);
    in_phase = 4'(ph);
    in_sol   = sol;
    in_eol   = eol;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 200);
    if (!in_ready) check1("send_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sol   = 1'b0;
    in_eol   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_row4(input int a, input int b, input int c, input int d, input int ph);
    send(a, ph, 1'b1, 1'b0);
    send(b, ph, 1'b0, 1'b0);
    send(c, ph, 1'b0, 1'b0);
    send(d, ph, 1'b0, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w[NT];
    int cnt;
    int pix;
    int sel;

    // Pin the model with hand-computed results.
    w = '{10, 20, 30, 40};
    checkn("pin_ph0_ramp", 32'(model_filt(w, 0)), 32'd20);
    checkn("pin_ph8_round", 32'(model_filt(w, 8)), 32'd25);
    w = '{255, 0, 0, 255};
    checkn("pin_ph8_clip_lo", 32'(model_filt(w, 8)), 32'd0);
    w = '{0, 255, 255, 0};
    checkn("pin_ph8_clip_hi", 32'(model_filt(w, 8)), 32'd255);
    w = '{1, 2, 3, 4};
    checkn("pin_ph3_small", 32'(model_filt(w, 3)), 32'd2);

    rst_n = 1'b0; in_valid = 1'b0; in_pix = '0; in_phase = '0;
    in_sol = 1'b0; in_eol = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_out_valid", out_valid, 1'b0);
    checkn("rst_out_pix", 32'(out_pix), 32'd0);
    check1("rst_out_eol", out_eol, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Phase 0 ramp and latency.
    send(10, 0, 1'b1, 1'b0);
    send(20, 0, 1'b0, 1'b0);
    send(30, 0, 1'b0, 1'b0);
    send(40, 0, 1'b0, 1'b0);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 20);
    checkn("latency_cycles", 32'(cnt - 1), 32'd3);
    checkn("ramp_first_pix", 32'(out_pix), 32'd20);
    @(posedge clk);
    #1;
    send(50, 0, 1'b0, 1'b1);
    idle(6);

    // Phase 8 rounding and both clip directions.
    send_row4(10, 20, 30, 40, 8);
    send_row4(255, 0, 0, 255, 8);
    send_row4(0, 255, 255, 0, 8);
    idle(6);

    // Back-pressure with a full pipe.
    fork
      begin
        for (int i = 0; i < 8; i++) send(i * 17 + 5, 8, i == 0, i == 7);
      end
      begin
        cnt = 0;
        do begin
          @(negedge clk);
          cnt++;
        end while (!out_valid && cnt < 50);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check1("bp_in_ready", in_ready, 1'b0);
          check1("bp_out_valid", out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(8);

    // Row restart after 6 samples, then 1-sample and 3-sample rows.
    for (int i = 0; i < 6; i++) send(30 + i * 20, 5, i == 0, i == 5);
    send(200, 11, 1'b1, 1'b0);
    send(100, 11, 1'b0, 1'b0);
    send(50, 11, 1'b0, 1'b0);
    send(25, 11, 1'b0, 1'b1);
    send(77, 0, 1'b1, 1'b1);
    send(1, 2, 1'b1, 1'b0);
    send(2, 2, 1'b0, 1'b0);
    send(3, 2, 1'b0, 1'b1);
    idle(8);

    // Reset with two results in flight.
    out_ready = 1'b0;
    send(10, 0, 1'b1, 1'b0);
    send(20, 0, 1'b0, 1'b0);
    send(30, 0, 1'b0, 1'b0);
    send(40, 0, 1'b0, 1'b0);
    send(50, 0, 1'b0, 1'b0);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 20);
    check1("pre_reset_valid", out_valid, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check1("async_rst_valid", out_valid, 1'b0);
    checkn("async_rst_pix", 32'(out_pix), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check1("post_reset_valid", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure.
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          if ($urandom_range(0, 4) == 0) idle(1);
          sel = int'($urandom_range(0, 7));
          pix = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(0, 255));
          send(pix, int'($urandom_range(0, 15)),
               $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
        out_ready = 1'b1;
      end
    join

    out_ready = 1'b1;
    idle(20);
    checkn("drain_empty", 32'(exp_pix_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
